// File: rtl/core_bridge_pkg.sv
// Shared types and helpers for the core memory bridge: FSM states, the default
// timeout read data and counter sizing/saturation functions.
package core_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
    function automatic int unsigned tmo_cnt_w(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/core_mem_bridge_if.sv
// Core-side valid/ready port plus the fetch and data req/gnt/rvalid channels.
// master = core/fabric environment, slave = the bridge.
interface core_mem_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              mem_valid;
    logic              mem_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_we;
    logic [STRB_W-1:0] dmem_be;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/core_bridge_perf.sv
// Saturating transaction and stall counters for the memory bridge.
module core_bridge_perf
    import core_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        load_inc,
    input  logic        store_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_load,
    output logic [31:0] perf_store,
    output logic [31:0] perf_stall
);

    logic [31:0] fetch_q, fetch_d;
    logic [31:0] load_q, load_d;
    logic [31:0] store_q, store_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        fetch_d = sat_inc32(fetch_q, fetch_inc);
        load_d  = sat_inc32(load_q, load_inc);
        store_d = sat_inc32(store_q, store_inc);
        stall_d = sat_inc32(stall_q, stall_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q <= '0;
            load_q  <= '0;
            store_q <= '0;
            stall_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            load_q  <= load_d;
            store_q <= store_d;
            stall_q <= stall_d;
        end
    end

    assign perf_fetch = fetch_q;
    assign perf_load  = load_q;
    assign perf_store = store_q;
    assign perf_stall = stall_q;

endmodule

// File: rtl/core_mem_bridge.sv
// Core valid/ready port to split fetch/data req-gnt-rvalid channels with watchdog
// and fetch trace. Perf counters are added when CORE_MEM_BRIDGE_PERF_EN is defined.
module core_mem_bridge
    import core_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    core_mem_bridge_if.slave  bus,
    output logic              bus_err,
    output logic [ADDR_W-1:0] bus_err_addr,
    output logic              dbg_fetch_valid,
    output logic [ADDR_W-1:0] dbg_fetch_pc,
    output logic [DATA_W-1:0] dbg_fetch_instr
`ifdef CORE_MEM_BRIDGE_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_load,
    output logic [31:0]       perf_store,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = tmo_cnt_w(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] be_q, be_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] bus_err_addr_q, bus_err_addr_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic [ADDR_W-1:0] dbg_pc_q, dbg_pc_d;
    logic [DATA_W-1:0] dbg_instr_q, dbg_instr_d;

    logic              gnt, rvalid, expire, to_err;
    logic [DATA_W-1:0] rdata;

    // Only the channel latched in IDLE is listened to.
    assign gnt    = sel_q ? bus.imem_gnt    : bus.dmem_gnt;
    assign rvalid = sel_q ? bus.imem_rvalid : bus.dmem_rvalid;
    assign rdata  = sel_q ? bus.imem_rdata  : bus.dmem_rdata;
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        we_d           = we_q;
        cnt_d          = cnt_q;
        imem_req_d     = 1'b0;
        dmem_req_d     = 1'b0;
        mem_ready_d    = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        bus_err_d      = bus_err_q;
        bus_err_addr_d = bus_err_addr_q;
        dbg_valid_d    = 1'b0;
        dbg_pc_d       = dbg_pc_q;
        dbg_instr_d    = dbg_instr_q;
        to_err         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    state_d    = REQ;
                    sel_d      = bus.mem_instr;
                    addr_d     = bus.mem_addr;
                    wdata_d    = bus.mem_wdata;
                    we_d       = |bus.mem_wstrb;
                    be_d       = (|bus.mem_wstrb) ? bus.mem_wstrb : '1;
                    cnt_d      = '0;
                    imem_req_d = bus.mem_instr;
                    dmem_req_d = !bus.mem_instr;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (expire) begin
                    to_err = 1'b1;
                end else if (gnt) begin
                    state_d = WAIT;
                end else begin
                    imem_req_d = sel_q;
                    dmem_req_d = !sel_q;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response landing on the expiry cycle still completes normally.
                if (rvalid) begin
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = we_q ? '0 : rdata;
                    if (sel_q) begin
                        dbg_valid_d = 1'b1;
                        dbg_pc_d    = addr_q;
                        dbg_instr_d = rdata;
                    end
                end else if (expire) begin
                    to_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (to_err) begin
            state_d     = ERR;
            mem_ready_d = 1'b1;
            mem_rdata_d = ERR_RDATA;
            bus_err_d   = 1'b1;
            if (!bus_err_q) bus_err_addr_d = addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sel_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            we_q           <= 1'b0;
            cnt_q          <= '0;
            imem_req_q     <= 1'b0;
            dmem_req_q     <= 1'b0;
            mem_ready_q    <= 1'b0;
            mem_rdata_q    <= '0;
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
            dbg_valid_q    <= 1'b0;
            dbg_pc_q       <= '0;
            dbg_instr_q    <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            we_q           <= we_d;
            cnt_q          <= cnt_d;
            imem_req_q     <= imem_req_d;
            dmem_req_q     <= dmem_req_d;
            mem_ready_q    <= mem_ready_d;
            mem_rdata_q    <= mem_rdata_d;
            bus_err_q      <= bus_err_d;
            bus_err_addr_q <= bus_err_addr_d;
            dbg_valid_q    <= dbg_valid_d;
            dbg_pc_q       <= dbg_pc_d;
            dbg_instr_q    <= dbg_instr_d;
        end
    end

    assign bus.mem_ready   = mem_ready_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.dmem_req    = dmem_req_q;
    assign bus.dmem_addr   = addr_q;
    assign bus.dmem_we     = we_q;
    assign bus.dmem_be     = be_q;
    assign bus.dmem_wdata  = wdata_q;
    assign bus_err         = bus_err_q;
    assign bus_err_addr    = bus_err_addr_q;
    assign dbg_fetch_valid = dbg_valid_q;
    assign dbg_fetch_pc    = dbg_pc_q;
    assign dbg_fetch_instr = dbg_instr_q;

`ifdef CORE_MEM_BRIDGE_PERF_EN
    core_bridge_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .fetch_inc  ((state_q == RESP) && sel_q),
        .load_inc   ((state_q == RESP) && !sel_q && !we_q),
        .store_inc  ((state_q == RESP) && !sel_q && we_q),
        .stall_inc  ((state_q == REQ) || (state_q == WAIT)),
        .perf_fetch (perf_fetch),
        .perf_load  (perf_load),
        .perf_store (perf_store),
        .perf_stall (perf_stall)
    );
`endif

endmodule

// File: tb/tb_core_mem_bridge.sv
// Randomized self-checking bench for core_mem_bridge against a cycle-count model
// of each transaction (wait counts -> completion cycle, data, timeout).
module tb_core_mem_bridge;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_err;
    logic [31:0] bus_err_addr;
    logic        dbg_fetch_valid;
    logic [31:0] dbg_fetch_pc;
    logic [31:0] dbg_fetch_instr;
`ifdef CORE_MEM_BRIDGE_PERF_EN
    logic [31:0] perf_fetch, perf_load, perf_store, perf_stall;
`endif

    always #5 clk = ~clk;

    core_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    core_mem_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .bus_err         (bus_err),
        .bus_err_addr    (bus_err_addr),
        .dbg_fetch_valid (dbg_fetch_valid),
        .dbg_fetch_pc    (dbg_fetch_pc),
        .dbg_fetch_instr (dbg_fetch_instr)
`ifdef CORE_MEM_BRIDGE_PERF_EN
        ,
        .perf_fetch      (perf_fetch),
        .perf_load       (perf_load),
        .perf_store      (perf_store),
        .perf_stall      (perf_stall)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: sticky error and expected counter values.
    bit          m_err      = 1'b0;
    logic [31:0] m_err_addr = '0;
    int          m_fetch = 0, m_load = 0, m_store = 0, m_stall = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic fabric_idle();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
    endtask

    // One transaction; g = REQ cycles without gnt, r = WAIT cycles without rvalid.
    // Called and returns at a negedge with the DUT idle.
    task automatic run_txn(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int g, input int r,
                           input logic [31:0] fab_data);
        int n, rc, req_end, last;
        bit tmo, st;
        logic [31:0] exp_rd;
        st      = (wstrb != 4'h0);
        n       = g + r + 2;
        tmo     = (n > int'(T));
        rc      = tmo ? int'(T) + 1 : n + 1;
        req_end = (g + 1 < int'(T)) ? g + 1 : int'(T);
        exp_rd  = (tmo || (!instr && st)) ? 32'h0 : fab_data;
        last    = ((rc > n) ? rc : n) + 1;

        bus.mem_valid = 1'b1;
        bus.mem_instr = instr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            bus.mem_valid = 1'b0;
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
            if (c == rc && tmo && !m_err) begin
                m_err      = 1'b1;
                m_err_addr = addr;
            end
            chk("mem_ready", bus.mem_ready, c == rc);
            if (c == rc) chk("mem_rdata", bus.mem_rdata, exp_rd);
            chk("imem_req", bus.imem_req, instr && c <= req_end);
            chk("dmem_req", bus.dmem_req, !instr && c <= req_end);
            if (c <= req_end) begin
                if (instr) begin
                    chk("imem_addr", bus.imem_addr, addr);
                end else begin
                    chk("dmem_addr", bus.dmem_addr, addr);
                    chk("dmem_we", bus.dmem_we, st);
                    chk("dmem_be", bus.dmem_be, st ? wstrb : 4'hF);
                    if (st) chk("dmem_wdata", bus.dmem_wdata, wdata);
                end
            end
            chk("dbg_valid", dbg_fetch_valid, c == rc && instr && !tmo);
            if (c == rc && instr && !tmo) begin
                chk("dbg_pc", dbg_fetch_pc, addr);
                chk("dbg_instr", dbg_fetch_instr, fab_data);
            end
            chk("bus_err", bus_err, m_err);
            chk("bus_err_addr", bus_err_addr, m_err_addr);

            // Selected channel follows the schedule; the other one carries noise.
            if (instr) begin
                bus.imem_gnt    = (c == g + 1);
                bus.imem_rvalid = (c == n);
                bus.imem_rdata  = (c == n) ? fab_data : $urandom;
                bus.dmem_gnt    = 1'($urandom);
                bus.dmem_rvalid = 1'($urandom);
                bus.dmem_rdata  = $urandom;
            end else begin
                bus.dmem_gnt    = (c == g + 1);
                bus.dmem_rvalid = (c == n);
                bus.dmem_rdata  = (c == n) ? fab_data : $urandom;
                bus.imem_gnt    = 1'($urandom);
                bus.imem_rvalid = 1'($urandom);
                bus.imem_rdata  = $urandom;
            end
        end
        fabric_idle();
        if (!tmo) begin
            if (instr) m_fetch++;
            else if (st) m_store++;
            else m_load++;
        end
        m_stall += tmo ? int'(T) : n;
    endtask

    task automatic check_perf();
`ifdef CORE_MEM_BRIDGE_PERF_EN
        chk("perf_fetch", perf_fetch, 32'(m_fetch));
        chk("perf_load", perf_load, 32'(m_load));
        chk("perf_store", perf_store, 32'(m_store));
        chk("perf_stall", perf_stall, 32'(m_stall));
`endif
    endtask

    initial begin
        bit          instr;
        logic [3:0]  strb;
        rst           = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        fabric_idle();

        @(negedge clk);
        chk("rst_ready", bus.mem_ready, 1'b0);
        chk("rst_ireq", bus.imem_req, 1'b0);
        chk("rst_dreq", bus.dmem_req, 1'b0);
        chk("rst_berr", bus_err, 1'b0);
        chk("rst_dbg", dbg_fetch_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(1'b1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'h0000_0013);
        run_txn(1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 2, 3, 32'h1234_5678);
        run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, 30, 0, 32'h5555_AAAA);
        run_txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 10, 32'h6666_7777);
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 2, 4, 32'hA5A5_5A5A);
        run_txn(1'b1, 32'h0000_0304, 32'h0, 4'h0, 0, 6, 32'h0040_0093);
        run_txn(1'b1, 32'h0000_0308, 32'h0, 4'h0, 7, 0, 32'h0000_0001);

        for (int i = 0; i < 40; i++) begin
            instr = 1'($urandom);
            strb  = (instr || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn(instr, {$urandom} & 32'hFFFF_FFFC, $urandom, strb,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
        end
        check_perf();

        // Async reset while a fetch sits in WAIT; a late rvalid must be dropped.
        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'b1;
        bus.mem_addr  = 32'h0000_0040;
        bus.mem_wstrb = 4'h0;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.imem_gnt  = 1'b1;
        @(negedge clk);
        bus.imem_gnt  = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", bus.mem_ready, 1'b0);
        chk("arst_rdata", bus.mem_rdata, 32'h0);
        chk("arst_ireq", bus.imem_req, 1'b0);
        chk("arst_dreq", bus.dmem_req, 1'b0);
        chk("arst_berr", bus_err, 1'b0);
        chk("arst_berr_addr", bus_err_addr, 32'h0);
        chk("arst_dbg", dbg_fetch_valid, 1'b0);
        m_err = 1'b0; m_err_addr = '0;
        m_fetch = 0; m_load = 0; m_store = 0; m_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("late_rvalid_ready", bus.mem_ready, 1'b0);
            chk("late_rvalid_ireq", bus.imem_req, 1'b0);
        end
        fabric_idle();

        run_txn(1'b1, 32'h0000_0080, 32'h0, 4'h0, 1, 1, 32'h0000_006F);
        run_txn(1'b0, 32'h0000_0084, 32'h0102_0304, 4'b1100, 0, 2, 32'h0);
        check_perf();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

endmodule
